csa_slice_add_sched: RTL

// - Shares one combinational SLICE_W-bit carry-select adder slice (csa_7bit-class) between two requesters.
// - Adds two WIDE_W = SLICE_W*NUM_SLICES operands over NUM_SLICES cycles, LSB slice first.
// - Keeps the inter-slice carry in a register and returns {cout, sum} tagged with the requester id.
// - Sits between the adder-classification workload generators and the shared slice adder.

---
 rtl/csa_slice_add_sched_if.sv | 57 +++++
 rtl/csa_slice_add_sched.sv | 107 ++++++++++
 2 files changed

// File: rtl/csa_slice_add_sched_if.sv
// Requester, shared-slice-adder and result signals of csa_slice_add_sched.
// Optional CSA_SCHED_SUB_EN adds the per-requester subtract selects.
interface csa_slice_add_sched_if #(
  parameter int SLICE_W    = 7,
  parameter int NUM_SLICES = 4
);
  localparam int WIDE_W = SLICE_W * NUM_SLICES;

  logic              i_req0_valid;
  logic              o_req0_ready;
  logic [WIDE_W-1:0] i_req0_a;
  logic [WIDE_W-1:0] i_req0_b;
  logic              i_req1_valid;
  logic              o_req1_ready;
  logic [WIDE_W-1:0] i_req1_a;
  logic [WIDE_W-1:0] i_req1_b;
`ifdef CSA_SCHED_SUB_EN
  logic              i_req0_sub;
  logic              i_req1_sub;
`endif
  logic [SLICE_W-1:0] o_slice_a;
  logic [SLICE_W-1:0] o_slice_b;
  logic               o_slice_cin;
  logic [SLICE_W-1:0] i_slice_sum;
  logic               i_slice_cout;
  logic              o_res_valid;
  logic              i_res_ready;
  logic [WIDE_W-1:0] o_res_sum;
  logic              o_res_cout;
  logic              o_res_id;

  // Scheduler side
  modport slave (
`ifdef CSA_SCHED_SUB_EN
    input  i_req0_sub, i_req1_sub,
`endif
    input  i_req0_valid, i_req0_a, i_req0_b,
    input  i_req1_valid, i_req1_a, i_req1_b,
    input  i_slice_sum, i_slice_cout, i_res_ready,
    output o_req0_ready, o_req1_ready,
    output o_slice_a, o_slice_b, o_slice_cin,
    output o_res_valid, o_res_sum, o_res_cout, o_res_id
  );

  // Requester / adder / consumer side
  modport master (
`ifdef CSA_SCHED_SUB_EN
    output i_req0_sub, i_req1_sub,
`endif
    output i_req0_valid, i_req0_a, i_req0_b,
    output i_req1_valid, i_req1_a, i_req1_b,
    output i_slice_sum, i_slice_cout, i_res_ready,
    input  o_req0_ready, o_req1_ready,
    input  o_slice_a, o_slice_b, o_slice_cin,
    input  o_res_valid, o_res_sum, o_res_cout, o_res_id
  );
endinterface

// File: rtl/csa_slice_add_sched.sv
// Round-robin scheduler running two requesters' wide adds through one shared slice adder, LSB slice first.
// Define CSA_SCHED_SUB_EN to enable per-request subtract (a + ~b + 1).
module csa_slice_add_sched #(
  parameter int SLICE_W    = 7,
  parameter int NUM_SLICES = 4
) (
  input logic                  i_clk,
  input logic                  i_rst,
  csa_slice_add_sched_if.slave bus
);
  localparam int IDX_W = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLICES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state;
  logic   rr_ptr;
  logic   id_q;
  logic   sub_q;
  logic   carry;
  logic   cout_q;
  logic [IDX_W-1:0] idx;
  logic [NUM_SLICES-1:0][SLICE_W-1:0] a_q;
  logic [NUM_SLICES-1:0][SLICE_W-1:0] b_q;
  logic [NUM_SLICES-1:0][SLICE_W-1:0] sum_q;

  logic grant1;
  logic acc0;
  logic acc1;
  logic sub_sel;

  // Requester 1 wins when alone or when the pointer favours it
  always_comb begin
    grant1 = bus.i_req1_valid & (~bus.i_req0_valid | rr_ptr);
    acc1   = ~i_rst & (state == IDLE) & grant1;
    acc0   = ~i_rst & (state == IDLE) & bus.i_req0_valid & ~grant1;
`ifdef CSA_SCHED_SUB_EN
    sub_sel = acc1 ? bus.i_req1_sub : bus.i_req0_sub;
`else
    sub_sel = 1'b0;
`endif
  end

  assign bus.o_req0_ready = acc0;
  assign bus.o_req1_ready = acc1;

  always_comb begin
    bus.o_slice_a   = '0;
    bus.o_slice_b   = '0;
    bus.o_slice_cin = 1'b0;
    if (state == RUN) begin
      bus.o_slice_a   = a_q[idx];
      bus.o_slice_b   = b_q[idx] ^ {SLICE_W{sub_q}};
      bus.o_slice_cin = carry;
    end
  end

  assign bus.o_res_valid = (state == DONE);
  assign bus.o_res_sum   = sum_q;
  assign bus.o_res_cout  = cout_q;
  assign bus.o_res_id    = id_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state  <= IDLE;
      rr_ptr <= 1'b0;
      id_q   <= 1'b0;
      sub_q  <= 1'b0;
      carry  <= 1'b0;
      cout_q <= 1'b0;
      idx    <= '0;
      a_q    <= '0;
      b_q    <= '0;
      sum_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (acc0 | acc1) begin
            a_q    <= acc1 ? bus.i_req1_a : bus.i_req0_a;
            b_q    <= acc1 ? bus.i_req1_b : bus.i_req0_b;
            id_q   <= acc1;
            sub_q  <= sub_sel;
            // Subtract seeds the +1 of the two's complement through the first carry-in
            carry  <= sub_sel;
            idx    <= '0;
            rr_ptr <= ~acc1;
            state  <= RUN;
          end
        end
        RUN: begin
          sum_q[idx] <= bus.i_slice_sum;
          carry      <= bus.i_slice_cout;
          if (idx == LAST_IDX) begin
            cout_q <= bus.i_slice_cout;
            state  <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (bus.i_res_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
